// File: rtl/fetch_unit.sv
// Fetch stage: issues one instruction-memory read at a time, predecodes each
// response for direct branches and halt, buffers instructions in a circular
// queue, and hands them to decode one per cycle.

package fetch_pkg;

  typedef struct packed {
    logic        done;
    logic [31:0] insnbits;
    logic [63:0] pc;
  } fetch_interface;

endpackage

module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_stall,
  input  logic                      in_redirect,
  input  logic [63:0]               in_redirect_pc,
  output logic                      out_imem_req,
  output logic [63:0]               out_imem_addr,
  input  logic                      in_imem_valid,
  input  logic [31:0]               in_imem_data,
  output fetch_pkg::fetch_interface out_fetch_sigs
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               dropped_q, dropped_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        insn_mem [QUEUE_DEPTH];
  logic [63:0]        pc_mem   [QUEUE_DEPTH];

  logic               q_full;
  logic               pop;
  logic               push;
  logic               req;
  logic               is_branch;
  logic               is_hlt;
  logic [63:0]        br_off;
  logic [63:0]        next_pc;

  // Queue status, handshake strobes and response predecode.
  always_comb begin
    q_full    = (count_q == CNT_W'(QUEUE_DEPTH));
    // A redirect kills the head this cycle, so nothing is handed to decode.
    pop       = (count_q != '0) && !in_stall && !in_redirect && !in_rst;
    // Only a live response in WAIT is kept; dropped or same-cycle-redirect ones are not.
    push      = in_imem_valid && (state_q == ST_WAIT) && !dropped_q && !in_redirect;
    // A dropped response must drain before a new read, or the two would be confused.
    req       = !in_rst && (state_q == ST_FETCH) && !q_full && !in_redirect && !dropped_q;
    is_branch = (in_imem_data[31:26] == 6'b000101) || (in_imem_data[31:26] == 6'b100101);
    is_hlt    = (in_imem_data[31:21] == 11'b11010100010) && (in_imem_data[4:0] == 5'b00000);
    br_off    = {{36{in_imem_data[25]}}, in_imem_data[25:0], 2'b00};
    next_pc   = pc_q + (is_branch ? br_off : 64'd4);
  end

  // Next-state logic for the fetch FSM, PC, drop flag and queue pointers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dropped_d = dropped_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    case (state_q)
      ST_FETCH: begin
        if (req) begin
          state_d = ST_WAIT;
        end
        if (dropped_q && in_imem_valid) begin
          dropped_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (push) begin
          pc_d    = next_pc;
          state_d = is_hlt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Redirect overrides everything; a read still in flight (and not
    // answered this very cycle) is remembered so its response is discarded.
    if (in_redirect) begin
      pc_d      = in_redirect_pc;
      state_d   = ST_FETCH;
      dropped_d = ((state_q == ST_WAIT) || dropped_q) && !in_imem_valid;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      dropped_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dropped_q <= dropped_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Queue storage write; contents are only meaningful under count_q.
  always_ff @(posedge in_clk) begin
    if (push && !in_rst) begin
      insn_mem[tail_q] <= in_imem_data;
      pc_mem[tail_q]   <= pc_q;
    end
  end

  // Memory request and decode-facing outputs.
  always_comb begin
    out_imem_req            = req;
    out_imem_addr           = pc_q;
    out_fetch_sigs.done     = pop;
    out_fetch_sigs.insnbits = insn_mem[head_q];
    out_fetch_sigs.pc       = pc_mem[head_q];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table with hand-computed
// outputs, plus a stall/saturation sequence driven by a 1-cycle memory model.

module tb_fetch_unit;

  import fetch_pkg::*;

  localparam logic [31:0] ADD = 32'h8B020020;
  localparam logic [31:0] BNEG = 32'h17FFFFFE;  // B,  imm26 = 0x3FFFFFE
  localparam logic [31:0] BL4 = 32'h94000004;   // BL, imm26 = 4
  localparam logic [31:0] HLT = 32'hD4400000;

  logic           in_clk = 1'b0;
  logic           in_rst;
  logic           in_stall;
  logic           in_redirect;
  logic [63:0]    in_redirect_pc;
  logic           out_imem_req;
  logic [63:0]    out_imem_addr;
  logic           in_imem_valid;
  logic [31:0]    in_imem_data;
  fetch_interface out_fetch_sigs;

  int total = 0;
  int bad = 0;

  fetch_unit #(
    .RESET_PC    (64'h1000),
    .QUEUE_DEPTH (4)
  ) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_stall       (in_stall),
    .in_redirect    (in_redirect),
    .in_redirect_pc (in_redirect_pc),
    .out_imem_req   (out_imem_req),
    .out_imem_addr  (out_imem_addr),
    .in_imem_valid  (in_imem_valid),
    .in_imem_data   (in_imem_data),
    .out_fetch_sigs (out_fetch_sigs)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rd;
    logic [63:0] rdpc;
    logic        v;
    logic [31:0] data;
    logic        ereq;
    logic [63:0] eaddr;
    logic        edone;
    logic [63:0] epc;
    logic [31:0] einsn;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, input logic stall, input logic rd,
                     input logic [63:0] rdpc, input logic v, input logic [31:0] data,
                     input logic ereq, input logic [63:0] eaddr,
                     input logic edone, input logic [63:0] epc, input logic [31:0] einsn);
    vec_t r;
    r.rst = rst; r.stall = stall; r.rd = rd; r.rdpc = rdpc; r.v = v; r.data = data;
    r.ereq = ereq; r.eaddr = eaddr; r.edone = edone; r.epc = epc; r.einsn = einsn;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge in_clk);
    #1;
  endtask

  int          nreq;
  logic        resp_next;
  logic        seen_req;
  int          req_after_full;

  initial begin
    in_rst = 1'b1; in_stall = 1'b0; in_redirect = 1'b0; in_redirect_pc = '0;
    in_imem_valid = 1'b0; in_imem_data = '0;

    //   rst stall rd rdpc                    v  data  | req addr                   done pc                     insn
    row(1, 0, 0, 64'h0,    0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 0 reset
    row(1, 0, 0, 64'h0,    0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 1
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h1000, 0, 64'h0,    32'h0);  // 2 first req
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 3
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h1004, 1, 64'h1000, ADD);    // 4
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 5
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h1008, 1, 64'h1004, ADD);    // 6
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 7
    row(0, 1, 0, 64'h0,    0, 32'h0,  1, 64'h100C, 0, 64'h0,    32'h0);  // 8 stalled
    row(0, 1, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 9 count 2
    row(0, 1, 0, 64'h0,    0, 32'h0,  1, 64'h1010, 0, 64'h0,    32'h0);  // 10 outstanding
    row(0, 1, 1, 64'h4000, 0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 11 redirect
    row(0, 0, 0, 64'h0,    0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 12 waiting drop
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 13 dropped resp
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h4000, 0, 64'h0,    32'h0);  // 14
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 15
    row(0, 0, 1, 64'h2000, 0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 16 redirect, head killed
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h2000, 0, 64'h0,    32'h0);  // 17
    row(0, 0, 0, 64'h0,    1, BNEG,   0, 64'h0,    0, 64'h0,    32'h0);  // 18 B -8
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h1FF8, 1, 64'h2000, BNEG);   // 19
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 20
    row(0, 0, 1, 64'h2000, 0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 21
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h2000, 0, 64'h0,    32'h0);  // 22
    row(0, 0, 0, 64'h0,    1, BL4,    0, 64'h0,    0, 64'h0,    32'h0);  // 23 BL +16
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h2010, 1, 64'h2000, BL4);    // 24
    row(0, 0, 0, 64'h0,    1, HLT,    0, 64'h0,    0, 64'h0,    32'h0);  // 25 halt
    row(0, 0, 0, 64'h0,    0, 32'h0,  0, 64'h0,    1, 64'h2010, HLT);    // 26
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 27 spurious valid
    row(0, 0, 0, 64'h0,    0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 28
    row(0, 0, 1, 64'h5000, 0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 29 leave halt
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h5000, 0, 64'h0,    32'h0);  // 30
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 31
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h5004, 1, 64'h5000, ADD);    // 32
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 33
    row(0, 1, 0, 64'h0,    0, 32'h0,  1, 64'h5008, 0, 64'h0,    32'h0);  // 34 count 1, WAIT
    row(0, 0, 1, 64'h6000, 1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 35 redirect+valid+pop
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h6000, 0, 64'h0,    32'h0);  // 36 empty, no drop
    row(1, 0, 0, 64'h0,    0, 32'h0,  0, 64'h0,    0, 64'h0,    32'h0);  // 37 reset in WAIT
    row(1, 0, 1, 64'h7000, 1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 38 rst beats redirect
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h1000, 0, 64'h0,    32'h0);  // 39
    row(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 0, 64'h0, 0, 64'h0, 32'h0);  // 40
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 41 dropped
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0);  // 42
    row(0, 0, 0, 64'h0,    1, ADD,    0, 64'h0,    0, 64'h0,    32'h0);  // 43 wrap
    row(0, 0, 0, 64'h0,    0, 32'h0,  1, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, ADD);  // 44

    foreach (vecs[i]) begin
      in_rst = vecs[i].rst; in_stall = vecs[i].stall;
      in_redirect = vecs[i].rd; in_redirect_pc = vecs[i].rdpc;
      in_imem_valid = vecs[i].v; in_imem_data = vecs[i].data;
      #2;
      check($sformatf("v%0d.req", i), 64'(out_imem_req), 64'(vecs[i].ereq));
      if (vecs[i].ereq)
        check($sformatf("v%0d.addr", i), out_imem_addr, vecs[i].eaddr);
      check($sformatf("v%0d.done", i), 64'(out_fetch_sigs.done), 64'(vecs[i].edone));
      if (vecs[i].edone) begin
        check($sformatf("v%0d.pc", i), out_fetch_sigs.pc, vecs[i].epc);
        check($sformatf("v%0d.insn", i), 64'(out_fetch_sigs.insnbits), 64'(vecs[i].einsn));
      end
      advance();
    end

    // Stall saturation: 10 stalled cycles, memory answers 1 cycle after each request.
    in_rst = 1'b1; in_stall = 1'b0; in_redirect = 1'b0; in_imem_valid = 1'b0;
    advance();
    advance();
    in_rst = 1'b0; in_stall = 1'b1; in_imem_data = ADD;
    resp_next = 1'b0; nreq = 0;
    for (int c = 0; c < 10; c++) begin
      in_imem_valid = resp_next;
      #2;
      if (out_imem_req) begin
        check($sformatf("sat.addr%0d", nreq), out_imem_addr, 64'h1000 + 64'(4 * nreq));
        nreq++;
      end
      check($sformatf("sat.done%0d", c), 64'(out_fetch_sigs.done), 64'h0);
      resp_next = out_imem_req;
      advance();
    end
    check("sat.nreq", 64'(nreq), 64'd4);

    // Release: four back-to-back done pulses, fetching resumes at 0x1010.
    in_stall = 1'b0; seen_req = 1'b0; req_after_full = 0;
    for (int c = 0; c < 4; c++) begin
      in_imem_valid = resp_next;
      #2;
      check($sformatf("rel.done%0d", c), 64'(out_fetch_sigs.done), 64'h1);
      check($sformatf("rel.pc%0d", c), out_fetch_sigs.pc, 64'h1000 + 64'(4 * c));
      if (out_imem_req && !seen_req) begin
        check("rel.addr", out_imem_addr, 64'h1010);
        seen_req = 1'b1;
        req_after_full = c;
      end
      resp_next = out_imem_req;
      advance();
    end
    check("rel.resumed", 64'(seen_req), 64'h1);
    check("rel.req_cycle", 64'(req_after_full), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, address of the first instruction fetched after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, instruction queue entries; SHALL be a power of two, at least 2.
REQ-003 SHALL have port in_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port in_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_stall, input, 1 bit: the downstream decode stage cannot accept an instruction this cycle.
REQ-006 SHALL have port in_redirect, input, 1 bit: ROB mispredict or control redirect strobe.
REQ-007 SHALL have port in_redirect_pc, input, 64 bits: new fetch PC, valid with in_redirect.
REQ-008 SHALL have port out_imem_req, input-side request strobe, output, 1 bit: one-cycle pulse per instruction-memory read.
REQ-009 SHALL have port out_imem_addr, output, 64 bits: read address, valid with out_imem_req.
REQ-010 SHALL have port in_imem_valid, input, 1 bit: one-cycle response strobe, arriving 1 or more cycles after the request.
REQ-011 SHALL have port in_imem_data, input, 32 bits: instruction word, valid with in_imem_valid.
REQ-012 SHALL have port out_fetch_sigs, output, fetch_interface: the fields done, insnbits[31:0] and pc[63:0] drive decode.

Function
REQ-013 SHALL keep a 64-bit fetch PC, a QUEUE_DEPTH-entry circular queue of {insnbits, pc}, an occupancy count and a state in {FETCH, WAIT, HALTED}.
REQ-014 SHALL, in FETCH, pulse out_imem_req with out_imem_addr = PC when count < QUEUE_DEPTH and in_redirect = 0, then go to WAIT; otherwise it SHALL stay in FETCH with out_imem_req = 0.
REQ-015 SHALL allow at most one outstanding request at a time.
REQ-016 SHALL, in WAIT, on in_imem_valid: enqueue {in_imem_data, requested PC}, update PC by REQ-017, and return to FETCH. The next request SHALL come no earlier than the following cycle.
REQ-017 SHALL predecode each response:
  - B (bits[31:26] = 000101) and BL (100101): next PC = pc + sign_extend(imm26 << 2).
  - All other instructions: next PC = pc + 4.
  - Addition SHALL be modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
REQ-018 SHALL, on HLT (bits[31:21] = 11010100010 and bits[4:0] = 00000), enqueue the HLT word and then enter HALTED; no requests are issued in HALTED.
REQ-019 SHALL, when count > 0, in_stall = 0 and in_redirect = 0, assert out_fetch_sigs.done for that cycle with the head entry's insnbits and pc, and pop the head at the clock edge.
REQ-020 SHALL otherwise hold out_fetch_sigs.done = 0; insnbits and pc SHALL still show the head entry (don't-care when the queue is empty).
REQ-021 SHALL support push and pop in the same cycle; the count is then unchanged and both pointers advance, wrapping modulo QUEUE_DEPTH.
REQ-022 SHALL, on in_redirect = 1 in any state, at the clock edge:
  - flush the queue (count = 0, pointers = 0);
  - set PC = in_redirect_pc and state = FETCH;
  - mark any outstanding response as dropped.
REQ-023 SHALL discard a response that arrives in the same cycle as in_redirect.
REQ-024 SHALL discard a dropped response when it arrives, without enqueueing it and without changing PC, and return to FETCH. No new request SHALL issue until that response arrives.
REQ-025 SHALL ignore in_imem_valid when no request is outstanding.
REQ-026 SHALL have a minimum latency of 1 cycle from a response edge to out_fetch_sigs.done for that instruction.

Reset
REQ-027 SHALL, when in_rst = 1 at a rising edge, set: PC = RESET_PC, state = FETCH, count = 0, pointers = 0, dropped flag = 0.
REQ-028 SHALL hold out_imem_req = 0 and out_fetch_sigs.done = 0 while in_rst is high.
REQ-029 SHALL issue the first request in the first cycle after in_rst falls, with out_imem_addr = RESET_PC.
REQ-030 SHALL, on reset during WAIT, ignore the pending response as in REQ-025.
REQ-031 SHALL give in_rst priority over in_redirect.

Verification
REQ-032 SHALL pass: reset with RESET_PC = 0x1000, memory returns ADD words with 1-cycle latency, in_stall = 0 -> requests at 0x1000, 0x1004, 0x1008; done pulses carry pc 0x1000, 0x1004, 0x1008 in order.
REQ-033 SHALL pass: B with imm26 = 0x3FFFFFE fetched at pc 0x2000 -> next out_imem_addr = 0x1FF8. BL with imm26 = 4 at 0x2000 -> next out_imem_addr = 0x2010.
REQ-034 SHALL pass: in_stall held high for 10 cycles -> count saturates at 4 with no further requests; releasing in_stall -> 4 consecutive done pulses with ascending pc, then fetching resumes.
REQ-035 SHALL pass: in_redirect to 0x4000 while a request at 0x1008 is outstanding and 2 entries are queued -> no done pulses for the old entries; the 0x1008 response is dropped; the next request is to 0x4000 after that response arrives.
REQ-036 SHALL pass: HLT word 0xD4400000 fetched at 0x3000 -> done pulse with pc 0x3000; no further requests; a later redirect to 0x5000 resumes fetching at 0x5000.
REQ-037 SHALL pass: redirect in the same cycle as in_imem_valid and a pending pop -> done = 0 that cycle; the response is discarded; the queue is empty the next cycle.
